wasm_import_host_bridge: RTL and testbench
==========================================

WASM_IMPORT_HOST_BRIDGE -- requirements
Module: wasm_import_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536: response wait limit in cycles; used only with WASM_IMPORT_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cpu_ext_halted_i  in  1  CPU halted on import call.
REQ-005 cpu_import_id_i  in  16  import index from CPU.
REQ-006 cpu_import_arg_i  in  128  args 0..3, arg0 in bits [31:0].
REQ-007 cpu_saved_next_pc_i  in  32  PC following the import call.
REQ-008 ext_resume_o  out  1  one-cycle resume pulse to CPU.
REQ-009 ext_resume_pc_o / ext_resume_val_o  out  32 each  resume PC and return value.
REQ-010 req_valid_o  out  1; req_ready_i  in  1  host request handshake.
REQ-011 req_id_o  out  16; req_arg_o  out  128  request payload.
REQ-012 rsp_valid_i  in  1; rsp_ready_o  out  1; rsp_val_i  in  32; rsp_err_i  in  1  host response handshake.
REQ-013 fault_o  out  1 sticky fault; fault_clr_i  in  1 fault clear; import_count_o  out  32 completed-import count.

Function
REQ-014 SHALL use states IDLE, REQ, WAIT, RESUME, DRAIN, FAULT.
REQ-015 IDLE: on cpu_ext_halted_i rising edge (registered previous value 0, current 1), latch id, args, pc; next state REQ.
REQ-016 No new capture while halted stays high; a level held through reset SHALL NOT trigger (previous-value register resets to 1).
REQ-017 REQ: req_valid_o=1, payload held stable; on req_valid_o&&req_ready_i -> WAIT the following cycle.
REQ-018 WAIT: rsp_ready_o=1; on rsp_valid_i&&!rsp_err_i latch rsp_val_i -> RESUME; with rsp_err_i -> FAULT.
REQ-019 RESUME: ext_resume_o=1 for exactly one cycle, ext_resume_pc_o=latched pc, ext_resume_val_o=latched value; import_count_o increments (wraps 2^32-1 -> 0); -> DRAIN.
REQ-020 DRAIN: wait until cpu_ext_halted_i==0, then -> IDLE; ext_resume_o stays 0.
REQ-021 FAULT: fault_o=1, no handshake outputs asserted; fault_clr_i -> DRAIN.
REQ-022 ext_resume_pc_o/ext_resume_val_o SHALL be 0 when ext_resume_o=0.
REQ-023 Halt-to-req_valid_o latency: 2 cycles after the halted rising edge is sampled; rsp accept-to-resume pulse: 1 cycle.
REQ-024 rsp_valid_i outside WAIT SHALL be ignored; rsp_ready_o=0 outside WAIT.

Reset
REQ-025 rst SHALL force IDLE, clear all latched payload, import_count_o=0, fault_o=0, all handshake/resume outputs 0 on the next edge, regardless of state (including mid-REQ/WAIT).

Configuration
REQ-026 With WASM_IMPORT_TIMEOUT_EN defined: cycle counter clears on WAIT entry; if WAIT persists TIMEOUT_CYCLES cycles without a response -> FAULT.
REQ-027 Without WASM_IMPORT_TIMEOUT_EN: no counter; WAIT holds indefinitely.

Structure
REQ-028 Enum import_bridge_state_t and struct import_req_t (id, args[4], pc) SHALL live in wasm_pkg.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 Halt rise, id=0x0003, args=1,2,3,4, pc=0x120, ready=1, rsp val=0xDEAD after 5 cycles -> req_valid 2 cycles after halt, resume pulse pc=0x120 val=0xDEAD, count=1.
REQ-031 req_ready_i low 10 cycles -> req_valid_o and payload stable 10 cycles, no resume.
REQ-032 rsp_err_i=1 -> fault_o=1, no resume; fault_clr_i with halted still high -> DRAIN, no retrigger until halted falls then rises.
REQ-033 Timeout macro on, TIMEOUT_CYCLES=8, no response -> fault_o=1 after 8 WAIT cycles; macro off -> still WAIT at cycle 1000.
REQ-034 rst asserted in WAIT -> all outputs 0 next cycle; held halted after reset -> no request.
REQ-035 Two back-to-back imports (halted drops 1 cycle between) -> two resumes, count=2.

Source files
------------

// File: rtl/wasm_pkg.sv
// Shared types for the WASM import host bridge: FSM state encoding and the
// captured import request (id, four 32-bit args, return PC).
package wasm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      RESUME = 3'd3,
      DRAIN  = 3'd4,
      FAULT  = 3'd5
   } import_bridge_state_t;

   typedef struct packed {
      logic [15:0]       id;
      logic [3:0][31:0]  args;
      logic [31:0]       pc;
   } import_req_t;

endpackage

// File: rtl/wasm_import_host_bridge.sv
// Bridges a halted CPU import call to a host request/response handshake and resumes the CPU.
// Optional WAIT-state response timeout is enabled by defining WASM_IMPORT_TIMEOUT_EN.
module wasm_import_host_bridge
   import wasm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cpu_ext_halted_i,
   input  logic [15:0]  cpu_import_id_i,
   input  logic [127:0] cpu_import_arg_i,
   input  logic [31:0]  cpu_saved_next_pc_i,
   output logic         ext_resume_o,
   output logic [31:0]  ext_resume_pc_o,
   output logic [31:0]  ext_resume_val_o,
   output logic         req_valid_o,
   input  logic         req_ready_i,
   output logic [15:0]  req_id_o,
   output logic [127:0] req_arg_o,
   input  logic         rsp_valid_i,
   output logic         rsp_ready_o,
   input  logic [31:0]  rsp_val_i,
   input  logic         rsp_err_i,
   output logic         fault_o,
   input  logic         fault_clr_i,
   output logic [31:0]  import_count_o
);

   import_bridge_state_t r_state;
   import_req_t          r_req;
   logic                 r_halted_prev;
   logic                 r_req_valid;
   logic                 r_rsp_ready;
   logic                 r_resume;
   logic [31:0]          r_resume_pc;
   logic [31:0]          r_resume_val;
   logic                 r_fault;
   logic [31:0]          r_count;
   logic                 w_halt_rise;

`ifdef WASM_IMPORT_TIMEOUT_EN
   localparam logic [31:0] LP_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]          r_wait_cnt;
`endif

   // Previous-halt register resets to 1 so a level held through reset is not an edge.
   assign w_halt_rise = cpu_ext_halted_i & ~r_halted_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_req         <= '0;
         r_halted_prev <= 1'b1;
         r_req_valid   <= 1'b0;
         r_rsp_ready   <= 1'b0;
         r_resume      <= 1'b0;
         r_resume_pc   <= '0;
         r_resume_val  <= '0;
         r_fault       <= 1'b0;
         r_count       <= '0;
`ifdef WASM_IMPORT_TIMEOUT_EN
         r_wait_cnt    <= '0;
`endif
      end else begin
         r_halted_prev <= cpu_ext_halted_i;
         r_resume      <= 1'b0;
         r_resume_pc   <= '0;
         r_resume_val  <= '0;
         case (r_state)
            IDLE: begin
               if (w_halt_rise) begin
                  r_req.id   <= cpu_import_id_i;
                  r_req.args <= cpu_import_arg_i;
                  r_req.pc   <= cpu_saved_next_pc_i;
                  r_state    <= REQ;
               end
            end
            REQ: begin
               if (r_req_valid && req_ready_i) begin
                  r_req_valid <= 1'b0;
                  r_rsp_ready <= 1'b1;
                  r_state     <= WAIT;
`ifdef WASM_IMPORT_TIMEOUT_EN
                  r_wait_cnt  <= '0;
`endif
               end else begin
                  r_req_valid <= 1'b1;
               end
            end
            WAIT: begin
               if (rsp_valid_i) begin
                  r_rsp_ready <= 1'b0;
                  if (rsp_err_i) begin
                     r_fault <= 1'b1;
                     r_state <= FAULT;
                  end else begin
                     r_resume     <= 1'b1;
                     r_resume_pc  <= r_req.pc;
                     r_resume_val <= rsp_val_i;
                     r_count      <= r_count + 32'd1;
                     r_state      <= RESUME;
                  end
               end
`ifdef WASM_IMPORT_TIMEOUT_EN
               else if (r_wait_cnt == LP_TIMEOUT_LAST) begin
                  r_rsp_ready <= 1'b0;
                  r_fault     <= 1'b1;
                  r_state     <= FAULT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 32'd1;
               end
`endif
            end
            RESUME: begin
               r_state <= DRAIN;
            end
            DRAIN: begin
               if (!cpu_ext_halted_i) begin
                  r_state <= IDLE;
               end
            end
            FAULT: begin
               if (fault_clr_i) begin
                  r_fault <= 1'b0;
                  r_state <= DRAIN;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ext_resume_o     = r_resume;
   assign ext_resume_pc_o  = r_resume_pc;
   assign ext_resume_val_o = r_resume_val;
   assign req_valid_o      = r_req_valid;
   assign req_id_o         = r_req.id;
   assign req_arg_o        = r_req.args;
   assign rsp_ready_o      = r_rsp_ready;
   assign fault_o          = r_fault;
   assign import_count_o   = r_count;

endmodule

// File: tb/tb_wasm_import_host_bridge.sv
// Directed self-checking bench for wasm_import_host_bridge; inputs driven and
// outputs sampled on the falling edge.
module tb_wasm_import_host_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_ext_halted_i;
   logic [15:0]  cpu_import_id_i;
   logic [127:0] cpu_import_arg_i;
   logic [31:0]  cpu_saved_next_pc_i;
   logic         ext_resume_o;
   logic [31:0]  ext_resume_pc_o;
   logic [31:0]  ext_resume_val_o;
   logic         req_valid_o;
   logic         req_ready_i;
   logic [15:0]  req_id_o;
   logic [127:0] req_arg_o;
   logic         rsp_valid_i;
   logic         rsp_ready_o;
   logic [31:0]  rsp_val_i;
   logic         rsp_err_i;
   logic         fault_o;
   logic         fault_clr_i;
   logic [31:0]  import_count_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_count = 0;

   wasm_import_host_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk                (clk),
      .rst                (rst),
      .cpu_ext_halted_i   (cpu_ext_halted_i),
      .cpu_import_id_i    (cpu_import_id_i),
      .cpu_import_arg_i   (cpu_import_arg_i),
      .cpu_saved_next_pc_i(cpu_saved_next_pc_i),
      .ext_resume_o       (ext_resume_o),
      .ext_resume_pc_o    (ext_resume_pc_o),
      .ext_resume_val_o   (ext_resume_val_o),
      .req_valid_o        (req_valid_o),
      .req_ready_i        (req_ready_i),
      .req_id_o           (req_id_o),
      .req_arg_o          (req_arg_o),
      .rsp_valid_i        (rsp_valid_i),
      .rsp_ready_o        (rsp_ready_o),
      .rsp_val_i          (rsp_val_i),
      .rsp_err_i          (rsp_err_i),
      .fault_o            (fault_o),
      .fault_clr_i        (fault_clr_i),
      .import_count_o     (import_count_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic halt_with(input logic [15:0] id, input logic [127:0] args, input logic [31:0] pc);
      cpu_import_id_i     = id;
      cpu_import_arg_i    = args;
      cpu_saved_next_pc_i = pc;
      cpu_ext_halted_i    = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; cpu_ext_halted_i = 1'b0; cpu_import_id_i = '0; cpu_import_arg_i = '0;
      cpu_saved_next_pc_i = '0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_val_i = '0;
      rsp_err_i = 1'b0; fault_clr_i = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      total++;
      if ({req_valid_o, rsp_ready_o, ext_resume_o, fault_o} !== 4'b0 || import_count_o !== 32'd0
          || req_id_o !== 16'd0 || req_arg_o !== 128'd0) begin
         bad++;
         $display("FAIL reset_state: valid=%b ready=%b resume=%b fault=%b count=%0d id=%h (want all 0)",
                  req_valid_o, rsp_ready_o, ext_resume_o, fault_o, import_count_o, req_id_o);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic;
      req_ready_i = 1'b1;
      halt_with(16'h0003, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h120);
      tick(1);
      total++;
      if (req_valid_o !== 1'b0) begin bad++; $display("FAIL basic_latency1: req_valid=%b want 0", req_valid_o); end
      tick(1);
      total++;
      if (req_valid_o !== 1'b1 || req_id_o !== 16'h0003 || req_arg_o !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         bad++;
         $display("FAIL basic_req: valid=%b id=%h arg=%h want 1/0003/4,3,2,1", req_valid_o, req_id_o, req_arg_o);
      end
      tick(1);
      total++;
      if (req_valid_o !== 1'b0 || rsp_ready_o !== 1'b1) begin
         bad++; $display("FAIL basic_wait: valid=%b rsp_ready=%b want 0/1", req_valid_o, rsp_ready_o);
      end
      for (int c = 0; c < 4; c++) begin
         tick(1);
         total++;
         if (ext_resume_o !== 1'b0 || ext_resume_pc_o !== 32'd0) begin
            bad++; $display("FAIL basic_no_early_resume: resume=%b pc=%h want 0/0", ext_resume_o, ext_resume_pc_o);
         end
      end
      rsp_valid_i = 1'b1; rsp_val_i = 32'hDEAD;
      tick(1);
      rsp_valid_i = 1'b0; rsp_val_i = '0;
      exp_count = exp_count + 1;
      total++;
      if (ext_resume_o !== 1'b1 || ext_resume_pc_o !== 32'h120 || ext_resume_val_o !== 32'hDEAD
          || import_count_o !== exp_count) begin
         bad++;
         $display("FAIL basic_resume: resume=%b pc=%h val=%h count=%0d want 1/120/dead/%0d",
                  ext_resume_o, ext_resume_pc_o, ext_resume_val_o, import_count_o, exp_count);
      end
      tick(1);
      total++;
      if (ext_resume_o !== 1'b0 || ext_resume_pc_o !== 32'd0 || ext_resume_val_o !== 32'd0) begin
         bad++;
         $display("FAIL basic_pulse_end: resume=%b pc=%h val=%h want 0/0/0", ext_resume_o, ext_resume_pc_o, ext_resume_val_o);
      end
      cpu_ext_halted_i = 1'b0;
      tick(2);
      $display("test_basic done count=%0d", import_count_o);
   endtask

   task automatic test_backpressure;
      req_ready_i = 1'b0;
      halt_with(16'h0042, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 32'h200);
      tick(2);
      rsp_valid_i = 1'b1; rsp_val_i = 32'h9999;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         total++;
         if (req_valid_o !== 1'b1 || req_id_o !== 16'h0042 || req_arg_o !== {32'hA4, 32'hA3, 32'hA2, 32'hA1}
             || ext_resume_o !== 1'b0 || rsp_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_cycle%0d: valid=%b id=%h resume=%b rsp_ready=%b want 1/0042/0/0",
                     c, req_valid_o, req_id_o, ext_resume_o, rsp_ready_o);
         end
      end
      rsp_valid_i = 1'b0;
      req_ready_i = 1'b1;
      tick(1);
      total++;
      if (rsp_ready_o !== 1'b1 || req_valid_o !== 1'b0) begin
         bad++; $display("FAIL stall_release: rsp_ready=%b valid=%b want 1/0", rsp_ready_o, req_valid_o);
      end
      rsp_valid_i = 1'b1; rsp_val_i = 32'h55;
      tick(1);
      rsp_valid_i = 1'b0;
      exp_count = exp_count + 1;
      total++;
      if (ext_resume_o !== 1'b1 || ext_resume_pc_o !== 32'h200 || ext_resume_val_o !== 32'h55
          || import_count_o !== exp_count) begin
         bad++;
         $display("FAIL stall_resume: resume=%b pc=%h val=%h count=%0d want 1/200/55/%0d",
                  ext_resume_o, ext_resume_pc_o, ext_resume_val_o, import_count_o, exp_count);
      end
      cpu_ext_halted_i = 1'b0;
      tick(2);
      $display("test_backpressure done");
   endtask

   task automatic test_error;
      req_ready_i = 1'b1;
      halt_with(16'h0007, {32'd0, 32'd0, 32'd0, 32'd9}, 32'h300);
      tick(3);
      rsp_valid_i = 1'b1; rsp_err_i = 1'b1; rsp_val_i = 32'h1;
      tick(1);
      total++;
      if (fault_o !== 1'b1 || ext_resume_o !== 1'b0 || rsp_ready_o !== 1'b0 || req_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL err_fault: fault=%b resume=%b rsp_ready=%b valid=%b want 1/0/0/0",
                  fault_o, ext_resume_o, rsp_ready_o, req_valid_o);
      end
      rsp_err_i = 1'b0;
      tick(2);
      rsp_valid_i = 1'b0;
      total++;
      if (fault_o !== 1'b1 || ext_resume_o !== 1'b0 || import_count_o !== exp_count) begin
         bad++; $display("FAIL err_sticky: fault=%b resume=%b count=%0d want 1/0/%0d", fault_o, ext_resume_o, import_count_o, exp_count);
      end
      fault_clr_i = 1'b1;
      tick(1);
      fault_clr_i = 1'b0;
      total++;
      if (fault_o !== 1'b0) begin bad++; $display("FAIL err_clear: fault=%b want 0", fault_o); end
      for (int c = 0; c < 5; c++) begin
         tick(1);
         total++;
         if (req_valid_o !== 1'b0) begin bad++; $display("FAIL err_no_retrigger: valid=%b want 0", req_valid_o); end
      end
      cpu_ext_halted_i = 1'b0;
      tick(1);
      halt_with(16'h0008, {32'd0, 32'd0, 32'd0, 32'd10}, 32'h304);
      tick(2);
      total++;
      if (req_valid_o !== 1'b1 || req_id_o !== 16'h0008) begin
         bad++; $display("FAIL err_retrigger: valid=%b id=%h want 1/0008", req_valid_o, req_id_o);
      end
      tick(1);
      rsp_valid_i = 1'b1; rsp_val_i = 32'h7;
      tick(1);
      rsp_valid_i = 1'b0;
      exp_count = exp_count + 1;
      total++;
      if (ext_resume_o !== 1'b1 || ext_resume_pc_o !== 32'h304 || import_count_o !== exp_count) begin
         bad++; $display("FAIL err_recover: resume=%b pc=%h count=%0d want 1/304/%0d", ext_resume_o, ext_resume_pc_o, import_count_o, exp_count);
      end
      cpu_ext_halted_i = 1'b0;
      tick(2);
      $display("test_error done");
   endtask

   task automatic test_timeout;
      req_ready_i = 1'b1;
      halt_with(16'h0010, {32'd0, 32'd0, 32'd0, 32'd1}, 32'h400);
      tick(3);
`ifdef WASM_IMPORT_TIMEOUT_EN
      tick(7);
      total++;
      if (fault_o !== 1'b0 || rsp_ready_o !== 1'b1) begin
         bad++; $display("FAIL timeout_early: fault=%b rsp_ready=%b want 0/1 after 7 wait cycles", fault_o, rsp_ready_o);
      end
      tick(1);
      total++;
      if (fault_o !== 1'b1 || rsp_ready_o !== 1'b0) begin
         bad++; $display("FAIL timeout_fault: fault=%b rsp_ready=%b want 1/0 after 8 wait cycles", fault_o, rsp_ready_o);
      end
      fault_clr_i = 1'b1;
      tick(1);
      fault_clr_i = 1'b0;
`else
      tick(1000);
      total++;
      if (fault_o !== 1'b0 || rsp_ready_o !== 1'b1 || ext_resume_o !== 1'b0) begin
         bad++; $display("FAIL wait_hold: fault=%b rsp_ready=%b resume=%b want 0/1/0", fault_o, rsp_ready_o, ext_resume_o);
      end
      rsp_valid_i = 1'b1; rsp_val_i = 32'h1234;
      tick(1);
      rsp_valid_i = 1'b0;
      exp_count = exp_count + 1;
      total++;
      if (ext_resume_o !== 1'b1 || ext_resume_val_o !== 32'h1234 || import_count_o !== exp_count) begin
         bad++; $display("FAIL wait_late_rsp: resume=%b val=%h count=%0d want 1/1234/%0d", ext_resume_o, ext_resume_val_o, import_count_o, exp_count);
      end
`endif
      cpu_ext_halted_i = 1'b0;
      tick(2);
      $display("test_timeout done");
   endtask

   task automatic test_reset_in_wait;
      req_ready_i = 1'b1;
      halt_with(16'h0020, {32'h11, 32'h22, 32'h33, 32'h44}, 32'h500);
      tick(3);
      total++;
      if (rsp_ready_o !== 1'b1) begin bad++; $display("FAIL rstw_in_wait: rsp_ready=%b want 1", rsp_ready_o); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_count = 0;
      total++;
      if ({req_valid_o, rsp_ready_o, ext_resume_o, fault_o} !== 4'b0 || import_count_o !== 32'd0
          || req_id_o !== 16'd0 || req_arg_o !== 128'd0 || ext_resume_pc_o !== 32'd0) begin
         bad++;
         $display("FAIL rstw_outputs: valid=%b ready=%b resume=%b fault=%b count=%0d id=%h want all 0",
                  req_valid_o, rsp_ready_o, ext_resume_o, fault_o, import_count_o, req_id_o);
      end
      for (int c = 0; c < 5; c++) begin
         tick(1);
         total++;
         if (req_valid_o !== 1'b0) begin bad++; $display("FAIL rstw_held_halt: valid=%b want 0", req_valid_o); end
      end
      cpu_ext_halted_i = 1'b0;
      tick(2);
      $display("test_reset_in_wait done");
   endtask

   task automatic test_back_to_back;
      req_ready_i = 1'b1;
      for (int n = 0; n < 2; n++) begin
         halt_with(16'h0030 + 16'(n), {32'd0, 32'd0, 32'd0, 32'(n)}, 32'h600 + 32'(n * 4));
         tick(3);
         rsp_valid_i = 1'b1; rsp_val_i = 32'hB000 + 32'(n);
         tick(1);
         rsp_valid_i = 1'b0;
         exp_count = exp_count + 1;
         total++;
         if (ext_resume_o !== 1'b1 || ext_resume_pc_o !== 32'h600 + 32'(n * 4)
             || ext_resume_val_o !== 32'hB000 + 32'(n) || import_count_o !== exp_count) begin
            bad++;
            $display("FAIL b2b_resume%0d: resume=%b pc=%h val=%h count=%0d want 1/%h/%h/%0d", n, ext_resume_o,
                     ext_resume_pc_o, ext_resume_val_o, import_count_o, 32'h600 + 32'(n * 4), 32'hB000 + 32'(n), exp_count);
         end
         tick(1);
         cpu_ext_halted_i = 1'b0;
         tick(1);
      end
      total++;
      if (import_count_o !== 32'd2) begin bad++; $display("FAIL b2b_count: count=%0d want 2", import_count_o); end
      $display("test_back_to_back done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
